// File: rtl/gpio_bank.sv
// WIDTH-pin GPIO bank: direction, atomic set/clear/toggle of OUT, synchronised IN, and sticky W1C edge interrupts.
// Optional input debounce is compiled in with GPIO_DEBOUNCE_EN. Reads are combinational; the single-cycle bus has no backpressure.
module gpio_bank #(
    parameter int WIDTH           = 16,
    parameter int DATA_W          = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic [2:0]        iAddress,
    input  logic [DATA_W-1:0] iData,
    output logic [DATA_W-1:0] oData,
    input  logic              iWrite,
    input  logic              iEnable,
    output logic              oInterrupt,
    input  logic [WIDTH-1:0]  iPinIn,
    output logic [WIDTH-1:0]  oPinOut,
    output logic [WIDTH-1:0]  oPinOE
);

    if (WIDTH < 1 || WIDTH > DATA_W || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
        $error("gpio_bank: illegal parameter combination");
    end

    localparam logic [2:0] A_DIR  = 3'd0;
    localparam logic [2:0] A_OUT  = 3'd1;
    localparam logic [2:0] A_IN   = 3'd2;
    localparam logic [2:0] A_SET  = 3'd3;
    localparam logic [2:0] A_CLR  = 3'd4;
    localparam logic [2:0] A_TGL  = 3'd5;
    localparam logic [2:0] A_RISE = 3'd6;
    localparam logic [2:0] A_FALL = 3'd7;

    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] rise_en_q;
    logic [WIDTH-1:0] fall_en_q;
    logic [WIDTH-1:0] status_q;
    logic [WIDTH-1:0] prev_q;
    logic             irq_q;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] syn;
    logic [WIDTH-1:0] in_val;
    logic [WIDTH-1:0] wdat;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] rise_hit;
    logic [WIDTH-1:0] fall_hit;
    logic             wr_en;

    // Synchroniser resets to 0, so a pin held high through reset looks like a fresh rising edge.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= iPinIn;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign syn = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] db_cnt [WIDTH];
    logic [WIDTH-1:0] db_q;

    // A pin's IN bit follows syn only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            db_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (syn[i] == db_q[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_q[i]   <= syn[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign in_val = db_q;
`else
    assign in_val = syn;
`endif

    assign wr_en    = iEnable && iWrite;
    assign wdat     = iData[WIDTH-1:0];
    assign w1c      = (wr_en && iAddress == A_FALL) ? wdat : '0;
    assign rise_hit = in_val & ~prev_q & rise_en_q;
    assign fall_hit = ~in_val & prev_q & fall_en_q;

    always_ff @(posedge iClock) begin
        if (iReset) begin
            dir_q     <= '0;
            out_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            prev_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            prev_q   <= in_val;
            // New edges are OR-ed after the clear so a same-cycle set beats W1C.
            status_q <= (status_q & ~w1c) | rise_hit | fall_hit;
            irq_q    <= |status_q;
            if (wr_en) begin
                case (iAddress)
                    A_DIR:   dir_q     <= wdat;
                    A_OUT:   out_q     <= wdat;
                    A_SET:   out_q     <= out_q | wdat;
                    A_CLR:   out_q     <= out_q & ~wdat;
                    A_TGL:   out_q     <= out_q ^ wdat;
                    A_RISE:  rise_en_q <= wdat;
                    A_FALL:  fall_en_q <= wdat;
                    default: ;
                endcase
            end
        end
    end

    // Address 7 reads STATUS; FALL is write-only and shares that address with W1C.
    always_comb begin
        oData = '0;
        if (iEnable && !iWrite) begin
            case (iAddress)
                A_DIR:   oData[WIDTH-1:0] = dir_q;
                A_OUT:   oData[WIDTH-1:0] = out_q;
                A_IN:    oData[WIDTH-1:0] = in_val;
                A_RISE:  oData[WIDTH-1:0] = rise_en_q;
                A_FALL:  oData[WIDTH-1:0] = status_q;
                default: oData = '0;
            endcase
        end
    end

    assign oPinOE     = dir_q;
    assign oPinOut    = out_q & dir_q;
    assign oInterrupt = irq_q;

endmodule
